phy_rx_deframer: RTL
====================

Name: phy_rx_deframer

Overview:
- Receive-side PHY deframer; the counterpart of the transmit framing that precedes msk_modulator.
- Takes the recovered bit stream from cdr (o_data/o_flag), hunts for the preamble and SFD, then parses the PHR length.
- Packs payload bits into nibbles and writes them into outFIFO under write-enable, with a FIFO-full check.
- Pulses report frame start, frame done and frame error.

Parameters:
- PREAMBLE_BITS, 32, minimum consecutive zero bits that qualify a preamble.
- SFD_VALUE, 8'hA7, start-of-frame delimiter, received LSB first.
- MAX_LEN, 127, maximum legal PHR length in octets.
- TIMEOUT_CYC, 4096, cycles without a bit strobe that abort an in-progress frame.

Ports:
- inClock  in  1  system clock.
- inReset  in  1  asynchronous reset, active-low.
- inBit  in  1  recovered data bit (cdr o_data).
- inBitValid  in  1  single-cycle strobe qualifying inBit (cdr o_flag).
- inFull  in  1  outFIFO full flag.
- outNibble  out  4  payload nibble to outFIFO.
- outNibbleValid  out  1  outFIFO write enable, 1 cycle per nibble.
- outLength  out  7  PHR length of the current/last accepted frame.
- outFrameStart  out  1  1-cycle pulse on SFD match.
- outFrameDone  out  1  1-cycle pulse after the last payload nibble is written.
- outFrameError  out  1  1-cycle pulse on abort (bad SFD excluded; see below).
- outBusy  out  1  high in SFD, PHR or PAYLOAD state.

Behaviour:
- Reset (inReset=0, async): state=HUNT; all counters and shift registers cleared; every output 0.
- Reset taken mid-frame drops the frame silently: no done or error pulse.
- All outputs are registered. Only bit-strobe cycles advance the parse.
- Bit order is LSB first. A nibble is {b3,b2,b1,b0}, with b0 the first received bit. Low nibble precedes high nibble.
- HUNT:
  - zeroCnt counts consecutive 0 bits and saturates at PREAMBLE_BITS.
  - A 1 bit with zeroCnt>=PREAMBLE_BITS goes to SFD: shift register seeded with that bit, bitCnt=1.
  - Otherwise a 1 bit clears zeroCnt.
- SFD:
  - Collect to 8 bits, then compare with SFD_VALUE.
  - Match: outFrameStart pulses on the next cycle; go to PHR.
  - Mismatch: go to HUNT with zeroCnt=0 and no error pulse.
- PHR:
  - Collect 8 bits; length = bits[6:0]; bit7 is ignored.
  - length==0 or length>MAX_LEN: outFrameError pulses; go to HUNT; outLength is unchanged.
  - Otherwise latch outLength, set nibRemain=2*length, go to PAYLOAD.
- PAYLOAD:
  - On every 4th bit, if inFull=0: outNibble/outNibbleValid asserted the cycle after that bit's strobe; nibRemain decrements.
  - Last nibble: outFrameDone is asserted in the same cycle as that final outNibbleValid; go to HUNT.
  - inFull=1 on a nibble boundary: no write; outFrameError pulses; go to HUNT.
- Timeout:
  - idleCnt clears on every inBitValid and increments otherwise, in SFD, PHR and PAYLOAD only.
  - idleCnt==TIMEOUT_CYC-1 with no strobe: outFrameError pulses; go to HUNT.
  - A strobe in the same cycle as the limit wins (no timeout).
- outFrameDone and outFrameError are never high together. outFrameStart is never asserted in the same cycle as either.
- A back-to-back frame (preamble right after done) must be accepted. zeroCnt restarts from 0 on entering HUNT.

Decomposition:
- Package phy_rx_pkg holds:
  - state enum {HUNT, SFD, PHR, PAYLOAD};
  - SFD and MAX_LEN default constants;
  - nibble and length widths.
- One natural sub-module, phy_bit_collector: shift register plus bit counter with a programmable group size (4 or 8) and a "group complete" strobe. It is instantiated once and reused across SFD, PHR and PAYLOAD.

Test Plan:
- Nominal frame: 32 zeros, SFD 0xA7, PHR 0x02, payload 0x3C,0x5A, strobe every 4 cycles.
  - outFrameStart pulses once; outLength=2.
  - Nibbles C,3,A,5 with one outNibbleValid each.
  - outFrameDone is asserted together with the final nibble (5).
- Short preamble: 31 zeros then SFD and a valid frame.
  - No outFrameStart and no nibbles.
  - Repeating with 40 zeros yields a normal frame.
- Bad SFD 0xA6 after 32 zeros: no start and no error pulse; stays idle. A following good frame is received correctly.
- PHR length 0, then PHR 0x80 (length 0): outFrameError pulse each time; outLength keeps its previous value.
- inFull=1 on the 3rd nibble boundary of a 4-nibble frame:
  - exactly 2 writes, then outFrameError;
  - outBusy=0 next cycle.
- Timeout and reset:
  - Halt strobes for 4096 cycles inside PAYLOAD: outFrameError exactly at the limit.
  - A strobe at cycle 4095 prevents it.
  - Asserting inReset mid-PAYLOAD: all outputs 0 immediately, with no done or error pulse.

Source files
------------

// File: rtl/phy_rx_deframer_pkg.sv
// Shared types and constants for the receive-side PHY deframer.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    SFD     = 2'd1,
    PHR     = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  localparam logic [7:0]  SFD_DEFAULT     = 8'hA7;
  localparam int unsigned MAX_LEN_DEFAULT = 32'd127;
  localparam int unsigned NIB_W           = 32'd4;
  localparam int unsigned LEN_W           = 32'd7;

  // A zero-length frame carries nothing and is treated as corrupt.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int unsigned max_len);
    return (len != 7'd0) && ({25'd0, len} <= max_len);
  endfunction

endpackage

// File: rtl/phy_rx_deframer_if.sv
// Bit-stream input and nibble/status output bundle of the deframer.
interface phy_rx_deframer_if;
  import phy_rx_pkg::*;

  logic             inBit;
  logic             inBitValid;
  logic             inFull;
  logic [NIB_W-1:0] outNibble;
  logic             outNibbleValid;
  logic [LEN_W-1:0] outLength;
  logic             outFrameStart;
  logic             outFrameDone;
  logic             outFrameError;
  logic             outBusy;

  modport master (
    output inBit, inBitValid, inFull,
    input  outNibble, outNibbleValid, outLength,
    input  outFrameStart, outFrameDone, outFrameError, outBusy
  );

  modport slave (
    input  inBit, inBitValid, inFull,
    output outNibble, outNibbleValid, outLength,
    output outFrameStart, outFrameDone, outFrameError, outBusy
  );

endinterface

// File: rtl/phy_rx_deframer_collector.sv
// LSB-first shift collector; o_word already contains the bit being strobed in,
// so o_group_done and o_word are valid together in the strobe cycle.
module phy_bit_collector
  import phy_rx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_shift,
  input  logic       i_bit,
  input  logic       i_nibble_mode,
  output logic [7:0] o_word,
  output logic       o_group_done
);

  logic [7:0] r_data;
  logic [2:0] r_cnt;
  logic [2:0] w_last;
  logic [7:0] w_word;

  assign w_last       = i_nibble_mode ? 3'd3 : 3'd7;
  assign o_group_done = i_shift && (r_cnt == w_last);
  assign o_word       = w_word;

  // Merge the incoming bit into its slot of the partially collected group.
  always_comb begin
    w_word = r_data;
    if (i_shift) begin
      w_word[r_cnt] = i_bit;
    end else begin
      w_word = r_data;
    end
  end

  // Group storage and bit position; a completed group restarts empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= 8'd0;
      r_cnt  <= 3'd0;
    end else if (i_clear) begin
      r_data <= 8'd0;
      r_cnt  <= 3'd0;
    end else if (i_shift) begin
      if (o_group_done) begin
        r_data <= 8'd0;
        r_cnt  <= 3'd0;
      end else begin
        r_data <= w_word;
        r_cnt  <= r_cnt + 3'd1;
      end
    end else begin
      r_data <= r_data;
      r_cnt  <= r_cnt;
    end
  end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer: preamble hunt, SFD match, PHR length parse, payload
// nibble delivery to the output FIFO, with inactivity and overflow aborts.
module phy_rx_deframer
  import phy_rx_pkg::*;
#(
  parameter int unsigned PREAMBLE_BITS = 32'd32,
  parameter logic [7:0]  SFD_VALUE     = SFD_DEFAULT,
  parameter int unsigned MAX_LEN       = MAX_LEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYC   = 32'd4096
) (
  input  logic             inClock,
  input  logic             inReset,
  phy_rx_deframer_if.slave bus
);

  localparam int unsigned ZW = $clog2(PREAMBLE_BITS + 32'd1);
  localparam int unsigned IW = $clog2(TIMEOUT_CYC);
  localparam logic [ZW-1:0] PRE_SAT  = ZW'(PREAMBLE_BITS);
  localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT_CYC - 32'd1);

  state_t           r_state;
  logic [ZW-1:0]    r_zero;
  logic [IW-1:0]    r_idle;
  logic [7:0]       r_nib_remain;
  logic [LEN_W-1:0] r_len;
  logic [NIB_W-1:0] r_nibble;
  logic             r_nib_valid;
  logic             r_start;
  logic             r_done;
  logic             r_err;
  logic             r_busy;

  logic             w_strobe;
  logic             w_seed;
  logic             w_timeout;
  logic             w_clear;
  logic [7:0]       w_word;
  logic             w_grp_done;
  logic [LEN_W-1:0] w_len;

  assign w_strobe  = bus.inBitValid;
  assign w_seed    = (r_state == HUNT) && w_strobe && bus.inBit && (r_zero >= PRE_SAT);
  // A strobe arriving exactly at the limit keeps the frame alive.
  assign w_timeout = (r_state != HUNT) && (r_idle == IDLE_LIM) && !w_strobe;
  assign w_clear   = ((r_state == HUNT) && !w_seed) || w_timeout;
  assign w_len     = w_word[LEN_W-1:0];

  phy_bit_collector u_collector (
    .i_clk         (inClock),
    .i_rst_n       (inReset),
    .i_clear       (w_clear),
    .i_shift       (w_strobe),
    .i_bit         (bus.inBit),
    .i_nibble_mode (r_state == PAYLOAD),
    .o_word        (w_word),
    .o_group_done  (w_grp_done)
  );

  assign bus.outNibble      = r_nibble;
  assign bus.outNibbleValid = r_nib_valid;
  assign bus.outLength      = r_len;
  assign bus.outFrameStart  = r_start;
  assign bus.outFrameDone   = r_done;
  assign bus.outFrameError  = r_err;
  assign bus.outBusy        = r_busy;

  // Frame parser FSM with registered status pulses and nibble output.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      r_state      <= HUNT;
      r_zero       <= '0;
      r_idle       <= '0;
      r_nib_remain <= 8'd0;
      r_len        <= 7'd0;
      r_nibble     <= 4'd0;
      r_nib_valid  <= 1'b0;
      r_start      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_nib_valid <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      if (w_timeout) begin
        r_err   <= 1'b1;
        r_state <= HUNT;
        r_busy  <= 1'b0;
        r_zero  <= '0;
        r_idle  <= '0;
      end else begin
        if ((r_state == HUNT) || w_strobe) begin
          r_idle <= '0;
        end else begin
          r_idle <= r_idle + IW'(1);
        end
        case (r_state)
          HUNT: begin
            if (w_strobe) begin
              if (!bus.inBit) begin
                r_zero <= (r_zero >= PRE_SAT) ? PRE_SAT : (r_zero + ZW'(1));
              end else if (w_seed) begin
                r_zero  <= '0;
                r_state <= SFD;
                r_busy  <= 1'b1;
              end else begin
                r_zero <= '0;
              end
            end
          end
          SFD: begin
            if (w_grp_done) begin
              if (w_word == SFD_VALUE) begin
                r_start <= 1'b1;
                r_state <= PHR;
              end else begin
                r_state <= HUNT;
                r_busy  <= 1'b0;
              end
            end
          end
          PHR: begin
            if (w_grp_done) begin
              if (len_legal(w_len, MAX_LEN)) begin
                r_len        <= w_len;
                r_nib_remain <= {w_len, 1'b0};
                r_state      <= PAYLOAD;
              end else begin
                r_err   <= 1'b1;
                r_state <= HUNT;
                r_busy  <= 1'b0;
              end
            end
          end
          PAYLOAD: begin
            if (w_grp_done) begin
              if (bus.inFull) begin
                r_err   <= 1'b1;
                r_state <= HUNT;
                r_busy  <= 1'b0;
              end else begin
                r_nibble     <= w_word[NIB_W-1:0];
                r_nib_valid  <= 1'b1;
                r_nib_remain <= r_nib_remain - 8'd1;
                if (r_nib_remain == 8'd1) begin
                  r_done  <= 1'b1;
                  r_state <= HUNT;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
          default: begin
            r_state <= HUNT;
            r_busy  <= 1'b0;
            r_zero  <= '0;
          end
        endcase
      end
    end
  end

endmodule
